// File: rtl/digit_frame_renderer_pkg.sv
// digit_font_pkg: glyph geometry, FSM states and the 3x5 digit font
package digit_font_pkg;

    localparam int GLYPH_H  = 5;
    localparam int GLYPH_PW = 3;

    typedef enum logic [1:0] {IDLE, RENDER, PUBLISH} state_e;

    // FONT[nibble][glyph_row], MSB is the leftmost pixel; A-F are blank
    localparam logic [GLYPH_PW-1:0] FONT [16][GLYPH_H] = '{
        '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
        '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
        '{3'b111, 3'b001, 3'b011, 3'b001, 3'b111},
        '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
        '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
        '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b001, 3'b001, 3'b010, 3'b010},
        '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111},
        '{5{3'b000}},
        '{5{3'b000}},
        '{5{3'b000}},
        '{5{3'b000}},
        '{5{3'b000}},
        '{5{3'b000}}
    };

endpackage

// File: rtl/digit_frame_renderer_if.sv
// digit_frame_renderer_if: request handshake and published-frame bundle
interface digit_frame_renderer_if #(
    parameter int DIGITS = 4,
    parameter int CELL_W = 4,
    parameter int ROWS   = 8
);
    localparam int FW = DIGITS * CELL_W;

    logic [4*DIGITS-1:0]  bcd_in;
    logic                 lz_en;
    logic [DIGITS-1:0]    blink_mask;
    logic                 blink_phase;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*FW-1:0]   frame_out;
    logic                 frame_valid;
    logic                 busy;

    modport master (
        output bcd_in, lz_en, blink_mask, blink_phase, in_valid,
        input  in_ready, frame_out, frame_valid, busy
    );

    modport slave (
        input  bcd_in, lz_en, blink_mask, blink_phase, in_valid,
        output in_ready, frame_out, frame_valid, busy
    );

endinterface

// File: rtl/digit_frame_renderer_glyph_row_rom.sv
// glyph_row_rom: nibble + glyph row index -> 3-pixel row, zero outside the glyph
module glyph_row_rom
    import digit_font_pkg::*;
(
    input  logic [3:0]          nibble_i,
    input  logic [2:0]          row_i,
    output logic [GLYPH_PW-1:0] pix_o
);

    assign pix_o = (row_i < 3'(GLYPH_H)) ? FONT[nibble_i][row_i] : '0;

endmodule

// File: rtl/digit_frame_renderer.sv
// digit_frame_renderer: renders a BCD value one row per clock into a shadow frame, then publishes it atomically
module digit_frame_renderer
    import digit_font_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CELL_W    = 4,
    parameter int ROWS      = 8,
    parameter int GLYPH_TOP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_frame_renderer_if.slave bus
);

    localparam int FW = DIGITS * CELL_W;
    localparam int CW = $clog2(ROWS);

    state_e              state_q, state_d;
    logic [CW-1:0]       row_cnt_q, row_cnt_d;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank_q, blank_d, lz_blank;
    logic                lz_run;
    logic [FW-1:0]       shadow_q [ROWS];
    logic [ROWS*FW-1:0]  shadow_flat, frame_q;
    logic                frame_valid_q;
    logic [FW-1:0]       row_data;
    logic [CW-1:0]       rel;
    logic                in_glyph, accept, last_row;

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = frame_valid_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_row = (row_cnt_q == CW'(ROWS - 1));
    assign rel      = row_cnt_q - CW'(GLYPH_TOP);
    assign in_glyph = (row_cnt_q >= CW'(GLYPH_TOP)) && (rel < CW'(GLYPH_H));

    // Leading zeros: blank from the top digit down until the first nonzero nibble; digit 0 always shown
    always_comb begin
        lz_blank = '0;
        lz_run   = bus.lz_en;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run      = lz_run && (bus.bcd_in[4*i +: 4] == 4'd0);
            lz_blank[i] = lz_run;
        end
        blank_d = lz_blank | (bus.blink_mask & {DIGITS{bus.blink_phase}});
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_cell
        logic [GLYPH_PW-1:0] pix;
        glyph_row_rom u_rom (
            .nibble_i (bcd_q[4*d +: 4]),
            .row_i    (rel[2:0]),
            .pix_o    (pix)
        );
        assign row_data[FW-1-d*CELL_W -: CELL_W] =
            (in_glyph && !blank_q[d]) ? CELL_W'(pix) << (CELL_W - GLYPH_PW) : '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_flat
        assign shadow_flat[(ROWS-r)*FW-1 -: FW] = shadow_q[r];
    end

    // Next-state: accept in IDLE, walk rows in RENDER, one publish cycle
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = RENDER;
                    row_cnt_d = '0;
                end
            end
            RENDER: begin
                row_cnt_d = row_cnt_q + CW'(1);
                if (last_row) state_d = PUBLISH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, latched request and the published frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            bcd_q         <= '0;
            blank_q       <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            frame_valid_q <= (state_q == PUBLISH);
            if (accept) begin
                bcd_q   <= bus.bcd_in;
                blank_q <= blank_d;
            end
            if (state_q == PUBLISH) frame_q <= shadow_flat;
        end
    end

    // Shadow frame, one row written per RENDER cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) shadow_q[i] <= '0;
        end else if (state_q == RENDER) begin
            shadow_q[row_cnt_q] <= row_data;
        end
    end

endmodule

// File: tb/tb_digit_frame_renderer.sv
// tb_digit_frame_renderer: directed checks of rendering, blanking, handshake timing and reset
module tb_digit_frame_renderer;

    localparam int DIGITS = 4, CELL_W = 4, ROWS = 8, GLYPH_TOP = 1;
    localparam int FW = DIGITS * CELL_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int passed = 0;
    int total  = 0;
    logic [ROWS*FW-1:0] fo;

    digit_frame_renderer_if #(.DIGITS(DIGITS), .CELL_W(CELL_W), .ROWS(ROWS)) bus ();

    digit_frame_renderer #(
        .DIGITS(DIGITS), .CELL_W(CELL_W), .ROWS(ROWS), .GLYPH_TOP(GLYPH_TOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign fo = bus.frame_out;

    function automatic logic [FW-1:0] row(input int r);
        return fo[(ROWS-r)*FW-1 -: FW];
    endfunction

    task automatic start(input logic [15:0] v, input logic lz, input logic [3:0] m, input logic ph);
        @(negedge clk);
        bus.bcd_in      = v;
        bus.lz_en       = lz;
        bus.blink_mask  = m;
        bus.blink_phase = ph;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_frame(output int lat, output int lo);
        lat = -1;
        lo  = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.frame_valid) lat = k;
            else if (!bus.in_ready) lo++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.frame_out !== '0) $display("FAIL rst_frame: got %h expected 0", bus.frame_out); else passed++;
        total++; if (bus.frame_valid !== 1'b0) $display("FAIL rst_fvalid: got %b expected 0", bus.frame_valid); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bus.in_ready); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy_after: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_basic();
        int lat, lo;
        start(16'h1234, 1'b0, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat); else passed++;
        total++; if (lo !== 9) $display("FAIL basic_ready_low: got %0d expected 9", lo); else passed++;
        total++; if (row(1) !== 16'hAEE4) $display("FAIL basic_row1: got %h expected aee4", row(1)); else passed++;
        total++; if (row(2) !== 16'hA22C) $display("FAIL basic_row2: got %h expected a22c", row(2)); else passed++;
        total++; if (row(3) !== 16'hE6E4) $display("FAIL basic_row3: got %h expected e6e4", row(3)); else passed++;
        total++; if (row(5) !== 16'h2EEE) $display("FAIL basic_row5: got %h expected 2eee", row(5)); else passed++;
        total++; if ({row(0), row(6), row(7)} !== 48'h0) $display("FAIL basic_blank_rows: got %h expected 0", {row(0), row(6), row(7)}); else passed++;
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b0) $display("FAIL basic_pulse_len: got %b expected 0", bus.frame_valid); else passed++;
    endtask

    task automatic test_lz();
        int lat, lo;
        start(16'h0050, 1'b1, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'hEE00) $display("FAIL lz_on_row1: got %h expected ee00", row(1)); else passed++;
        start(16'h0050, 1'b0, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'hEEEE) $display("FAIL lz_off_row1: got %h expected eeee", row(1)); else passed++;
        start(16'h00A0, 1'b1, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'hE000) $display("FAIL lz_a_stop_row1: got %h expected e000", row(1)); else passed++;
        start(16'h0000, 1'b1, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'hE000) $display("FAIL lz_zero_row1: got %h expected e000", row(1)); else passed++;
    endtask

    task automatic test_blink();
        int lat, lo;
        start(16'h1234, 1'b0, 4'b0001, 1'b1);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'h0EE4) $display("FAIL blink_on_row1: got %h expected 0ee4", row(1)); else passed++;
        start(16'h1234, 1'b0, 4'b0001, 1'b0);
        wait_frame(lat, lo);
        total++; if (row(1) !== 16'hAEE4) $display("FAIL blink_off_row1: got %h expected aee4", row(1)); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int pulses = 0;
        @(negedge clk);
        bus.bcd_in      = 16'h5678;
        bus.lz_en       = 1'b0;
        bus.blink_mask  = 4'b0000;
        bus.blink_phase = 1'b0;
        bus.in_valid    = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.in_ready) acc.push_back(k);
            if (bus.frame_valid) pulses++;
        end
        bus.in_valid = 1'b0;
        total++; if (acc.size() !== 3) $display("FAIL b2b_accepts: got %0d expected 3", acc.size()); else passed++;
        if (acc.size() >= 3) begin
            total++; if (acc[1] - acc[0] !== 10) $display("FAIL b2b_gap1: got %0d expected 10", acc[1] - acc[0]); else passed++;
            total++; if (acc[2] - acc[1] !== 10) $display("FAIL b2b_gap2: got %0d expected 10", acc[2] - acc[1]); else passed++;
        end
        total++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses); else passed++;
        repeat (12) @(negedge clk);
        total++; if (row(1) !== 16'hEEEE) $display("FAIL b2b_row1: got %h expected eeee", row(1)); else passed++;
    endtask

    task automatic test_busy_ignore();
        int lat, lo;
        int pulses = 0;
        start(16'h1234, 1'b0, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        bus.bcd_in      = 16'h9999;
        bus.lz_en       = 1'b1;
        bus.blink_mask  = 4'b1111;
        bus.blink_phase = 1'b1;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_frame(lat, lo);
        total++; if (lat !== 5) $display("FAIL busy_latency: got %0d expected 5", lat); else passed++;
        total++; if (row(1) !== 16'hAEE4) $display("FAIL busy_row1: got %h expected aee4", row(1)); else passed++;
        total++; if (row(5) !== 16'h2EEE) $display("FAIL busy_row5: got %h expected 2eee", row(5)); else passed++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.frame_valid) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL busy_no_queue: got %0d pulses expected 0", pulses); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL busy_idle_after: got %b expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_mid_reset();
        int lat, lo;
        int pulses = 0;
        start(16'h1234, 1'b0, 4'b0000, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.frame_out !== '0) $display("FAIL mid_rst_frame: got %h expected 0", bus.frame_out); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.frame_valid !== 1'b0) $display("FAIL mid_rst_fvalid: got %b expected 0", bus.frame_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", bus.in_ready); else passed++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.frame_valid) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL mid_rst_no_publish: got %0d pulses expected 0", pulses); else passed++;
        total++; if (bus.frame_out !== '0) $display("FAIL mid_rst_frame_held: got %h expected 0", bus.frame_out); else passed++;
        start(16'h1234, 1'b0, 4'b0000, 1'b0);
        wait_frame(lat, lo);
        total++; if (lat !== 9) $display("FAIL mid_rst_relatency: got %0d expected 9", lat); else passed++;
        total++; if (row(1) !== 16'hAEE4) $display("FAIL mid_rst_row1: got %h expected aee4", row(1)); else passed++;
        total++; if (row(5) !== 16'h2EEE) $display("FAIL mid_rst_row5: got %h expected 2eee", row(5)); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.bcd_in      = '0;
        bus.lz_en       = 1'b0;
        bus.blink_mask  = '0;
        bus.blink_phase = 1'b0;
        bus.in_valid    = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();
        test_basic();
        test_lz();
        test_blink();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/digit_frame_renderer.md
Name: digit_frame_renderer

Overview:
- Sequential, parametrised successor to the combinational BCD-to-bitmap stage. Takes a packed BCD value of DIGITS digits over a valid/ready handshake and renders it into a ROWS x (DIGITS*CELL_W) frame, one row per clock.
- Adds leading-zero suppression and per-digit blinking.
- The completed frame is published atomically from a shadow buffer to the display scan-out logic.

Parameters:
- DIGITS, 4, number of BCD digits and character cells.
- CELL_W, 4, columns per cell (>= 3); glyph pixels occupy the cell's 3 MSB columns, the rest are 0.
- ROWS, 8, frame rows (>= GLYPH_TOP+5).
- GLYPH_TOP, 1, first frame row holding glyph row 0; the glyph occupies rows GLYPH_TOP..GLYPH_TOP+4, all other rows are 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bcd_in  in  4*DIGITS  digit d = bcd_in[4d+3:4d].
- lz_en  in  1  leading-zero suppression enable, sampled on accept.
- blink_mask  in  DIGITS  bit d set = digit d blinks, sampled on accept.
- blink_phase  in  1  1 = blinking digits blank, sampled on accept.
- in_valid  in  1  request to render.
- in_ready  out  1  high only in IDLE.
- frame_out  out  ROWS*DIGITS*CELL_W  published frame. Row r = frame_out[(ROWS-r)*FW-1 -: FW], where FW = DIGITS*CELL_W. Row 0 is at the MSBs.
- frame_valid  out  1  one-cycle pulse when frame_out updates.
- busy  out  1  high in RENDER and PUBLISH.

Behaviour:
- Cell placement: digit d occupies row bits [FW-1-d*CELL_W -: CELL_W]. Digit 0 is leftmost.
- Font, glyph rows 0..4, MSB = left pixel:
  - 0 = 111,101,101,101,111
  - 1 = 010,110,010,010,111
  - 2 = 111,001,111,100,111
  - 3 = 111,001,011,001,111
  - 4 = 101,101,111,001,001
  - 5 = 111,100,111,001,111
  - 6 = 111,100,111,101,111
  - 7 = 111,001,001,010,010
  - 8 = 111,101,111,101,111
  - 9 = 111,101,111,001,111
  - Nibbles A–F render a blank cell.
- Blank rules, computed on accept and held for the whole render:
  - Leading zeros: if lz_en, digits from index DIGITS-1 downward whose nibble is 0 are blank up to the first nonzero nibble. Any of 1–F stops the suppression. Digit 0 is never suppressed.
  - Blinking: digit d is blank if blink_mask[d] && blink_phase.
- FSM:
  - IDLE: in_ready=1. in_valid && in_ready = accept. Latch inputs, clear row counter, go to RENDER.
  - RENDER: each cycle write shadow row[row_cnt], then row_cnt++. After row ROWS-1 is written, go to PUBLISH.
  - PUBLISH: frame_out <= shadow, frame_valid=1 for this single cycle, go to IDLE.
- Latency: accept at edge T. Rows are written at edges T+1..T+ROWS. frame_out changes and frame_valid goes high at edge T+ROWS+1. Throughput is one frame per ROWS+2 cycles.
- in_valid while busy is ignored; no request is queued.
- frame_out holds its value between publishes. Input changes after accept do not affect the frame in progress.
- Reset, asserted at any time including mid-render:
  - State goes to IDLE; render aborts with no partial publish.
  - frame_out=0, shadow=0, frame_valid=0, busy=0.
  - in_ready=1 from the first clock after deassertion.
- Widths: row_cnt is $clog2(ROWS) bits. No arithmetic beyond the counter.

Decomposition:
- Package digit_font_pkg:
  - GLYPH_H=5, GLYPH_PW=3.
  - FSM state enum {IDLE, RENDER, PUBLISH}.
  - Font constant array [16][5] of 3-bit rows, with A–F all zero.
- One sub-module, glyph_row_rom: combinational nibble + glyph-row index -> 3-bit pixel row. Instantiated DIGITS times via generate.

Test Plan (DIGITS=4, CELL_W=4, ROWS=8, GLYPH_TOP=1; row1 = frame_out[111:96], row5 = frame_out[47:32]):
- 16'h1234, lz_en=0, mask=0 -> frame_valid at T+9; row1=16'hAEE4, row5=16'h2EEE; rows 0, 6 and 7 are 0; in_ready=0 for T+1..T+9.
- 16'h0050 with lz_en=1 -> row1=16'hEE00. Same value with lz_en=0 -> row1=16'hEEEE.
- 16'h00A0, lz_en=1 -> row1=16'hE000: the A cell is blank but stops suppression; digit 0 is shown.
- 16'h1234, blink_mask=4'b0001: blink_phase=1 -> row1=16'h0EE4; blink_phase=0 -> row1=16'hAEE4.
- Back-to-back requests with in_valid held high -> accepts exactly ROWS+2 cycles apart. A 16'h9999 pulse while busy -> no effect on the frame in progress.
- Assert rst_n at T+4 mid-render -> frame_out=0, frame_valid never pulses, in_ready=1 after deassertion; a fresh 16'h1234 then renders correctly.
